carga_color: RTL and testbench

Operator-entry front end for the paint dispenser. It captures three 4-bit intensities (R, G, B) from the panel switches, one per debounced press of the load button, and presents them to the motor timer. It holds B at the "loading" sentinel 16 until all three are entered. A further press confirms and fires a one-cycle `enter` start pulse. The block then locks out entry until the timer reports the blue phase finished or a timeout expires.

---
 rtl/carga_color.sv | 180 ++++++++++++++++++
 tb/tb_carga_color.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/carga_color.sv
// Operator-entry front end for the paint dispenser: captures R, G, B intensities
// one per debounced load press, confirms with a one-cycle start pulse, then waits for the timer.
module carga_color #(
  parameter int DEBOUNCE = 500_000,
  parameter int TIMEOUT  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dato,
  input  logic       cargar,
  input  logic       cancelar,
  input  logic       fin_ciclo,
  output logic [4:0] R,
  output logic [4:0] G,
  output logic [4:0] B,
  output logic       enter,
  output logic [2:0] fase,
  output logic       ocupado,
  output logic       error
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
  localparam logic [4:0]    B_LOADING = 5'd16;

  typedef enum logic [2:0] {
    CARGA_R  = 3'd0,
    CARGA_G  = 3'd1,
    CARGA_B  = 3'd2,
    CONFIRMA = 3'd3,
    DISPENSA = 3'd4
  } state_t;

  state_t        state_r;
  logic          cargar_s1_r, cargar_s2_r;
  logic          cancelar_s1_r, cancelar_s2_r;
  logic          fin_s1_r, fin_s2_r, fin_prev_r;
  logic [3:0]    dato_s1_r, dato_s2_r;
  logic          deb_r;
  logic [DW-1:0] deb_cnt_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          press_s;
  logic          fin_evt_s;

  // Two-flop synchronizers for every asynchronous panel/timer input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cargar_s1_r   <= 1'b0;
      cargar_s2_r   <= 1'b0;
      cancelar_s1_r <= 1'b0;
      cancelar_s2_r <= 1'b0;
      fin_s1_r      <= 1'b0;
      fin_s2_r      <= 1'b0;
      fin_prev_r    <= 1'b0;
      dato_s1_r     <= 4'd0;
      dato_s2_r     <= 4'd0;
    end else begin
      cargar_s1_r   <= cargar;
      cargar_s2_r   <= cargar_s1_r;
      cancelar_s1_r <= cancelar;
      cancelar_s2_r <= cancelar_s1_r;
      fin_s1_r      <= fin_ciclo;
      fin_s2_r      <= fin_s1_r;
      fin_prev_r    <= fin_s2_r;
      dato_s1_r     <= dato;
      dato_s2_r     <= dato_s1_r;
    end
  end

  // Load-button debouncer: a new level must persist DEBOUNCE cycles to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r     <= 1'b0;
      deb_cnt_r <= '0;
    end else if (cargar_s2_r == deb_r) begin
      deb_cnt_r <= '0;
    end else if (deb_cnt_r == DEB_MAX) begin
      deb_r     <= cargar_s2_r;
      deb_cnt_r <= '0;
    end else begin
      deb_cnt_r <= deb_cnt_r + 1'b1;
    end
  end

  // A press is the cycle on which the debounced level flips 0->1.
  assign press_s   = ~deb_r & cargar_s2_r & (deb_cnt_r == DEB_MAX);
  assign fin_evt_s = fin_s2_r & ~fin_prev_r;

  // Entry sequencer with registered operator/timer outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= CARGA_R;
      R         <= 5'd0;
      G         <= 5'd0;
      B         <= B_LOADING;
      enter     <= 1'b0;
      fase      <= 3'b001;
      ocupado   <= 1'b0;
      error     <= 1'b0;
      tmo_cnt_r <= '0;
    end else begin
      enter <= 1'b0;
      // Cancel outranks a same-cycle press everywhere except while dispensing.
      if ((state_r != DISPENSA) && cancelar_s2_r) begin
        state_r <= CARGA_R;
        R       <= 5'd0;
        G       <= 5'd0;
        B       <= B_LOADING;
        fase    <= 3'b001;
      end else begin
        case (state_r)
          CARGA_R: begin
            if (press_s) begin
              R       <= {1'b0, dato_s2_r};
              state_r <= CARGA_G;
              fase    <= 3'b010;
            end else begin
              state_r <= CARGA_R;
            end
          end
          CARGA_G: begin
            if (press_s) begin
              G       <= {1'b0, dato_s2_r};
              state_r <= CARGA_B;
              fase    <= 3'b100;
            end else begin
              state_r <= CARGA_G;
            end
          end
          CARGA_B: begin
            if (press_s) begin
              B       <= {1'b0, dato_s2_r};
              state_r <= CONFIRMA;
              fase    <= 3'b111;
            end else begin
              state_r <= CARGA_B;
            end
          end
          CONFIRMA: begin
            if (press_s) begin
              enter     <= 1'b1;
              error     <= 1'b0;
              tmo_cnt_r <= '0;
              ocupado   <= 1'b1;
              fase      <= 3'b000;
              state_r   <= DISPENSA;
            end else begin
              state_r <= CONFIRMA;
            end
          end
          DISPENSA: begin
            if (fin_evt_s) begin
              state_r <= CARGA_R;
              B       <= B_LOADING;
              fase    <= 3'b001;
              ocupado <= 1'b0;
            end else if (tmo_cnt_r == TMO_MAX) begin
              error   <= 1'b1;
              state_r <= CARGA_R;
              B       <= B_LOADING;
              fase    <= 3'b001;
              ocupado <= 1'b0;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + 1'b1;
            end
          end
          default: begin
            state_r <= CARGA_R;
            B       <= B_LOADING;
            fase    <= 3'b001;
            ocupado <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_carga_color.sv
// Directed self-checking bench for carga_color with DEBOUNCE=4, TIMEOUT=20.
module tb_carga_color;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dato;
  logic       cargar, cancelar, fin_ciclo;
  logic [4:0] R, G, B;
  logic       enter;
  logic [2:0] fase;
  logic       ocupado, error;

  int errors = 0;
  int checks = 0;

  carga_color #(.DEBOUNCE(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .dato(dato), .cargar(cargar), .cancelar(cancelar),
    .fin_ciclo(fin_ciclo), .R(R), .G(G), .B(B), .enter(enter), .fase(fase),
    .ocupado(ocupado), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_btn();
    cargar = 1'b0;
    tick(8);
  endtask

  // Raise the button; returns just before the edge on which the press is accepted.
  task automatic raise_wait(input logic [3:0] d);
    dato   = d;
    cargar = 1'b1;
    tick(5);
  endtask

  task automatic load(input logic [3:0] d);
    raise_wait(d);
    tick(1);
    release_btn();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dato = 4'd0; cargar = 1'b0; cancelar = 1'b0; fin_ciclo = 1'b0;
    tick(2);
    chk("rst_R", R, 5'd0);
    chk("rst_G", G, 5'd0);
    chk("rst_B", B, 5'd16);
    chk("rst_enter", enter, 1'b0);
    chk("rst_fase", fase, 3'b001);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_error", error, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Bounce: 1,0,1,0 then held high; raw high held from edge a+4 -> press at a+9.
    dato = 4'd5;
    cargar = 1'b1; tick(1);
    cargar = 1'b0; tick(1);
    cargar = 1'b1; tick(1);
    cargar = 1'b0; tick(1);
    cargar = 1'b1; tick(5);
    chk("bounce_no_early_fase", fase, 3'b001);
    chk("bounce_no_early_R", R, 5'd0);
    tick(1);
    chk("bounce_R", R, 5'd5);
    chk("bounce_fase", fase, 3'b010);
    chk("bounce_B_loading", B, 5'd16);
    tick(100);
    chk("held_no_second_fase", fase, 3'b010);
    chk("held_no_second_G", G, 5'd0);
    release_btn();

    // G and B land exactly 5 edges after the raw rise.
    raise_wait(4'd10);
    chk("G_before", G, 5'd0);
    tick(1);
    chk("G_after", G, 5'd10);
    chk("fase_G", fase, 3'b100);
    chk("B_still_loading", B, 5'd16);
    release_btn();
    raise_wait(4'd15);
    chk("B_before", B, 5'd16);
    tick(1);
    chk("B_after", B, 5'd15);
    chk("fase_confirm", fase, 3'b111);
    release_btn();

    // Full cycle: confirm at edge c, cancel ignored, fin_ciclo event at c+10.
    raise_wait(4'd0);
    chk("enter_pre", enter, 1'b0);
    tick(1);
    chk("enter_pulse", enter, 1'b1);
    chk("ocupado_on", ocupado, 1'b1);
    chk("fase_disp", fase, 3'b000);
    chk("B_in_disp", B, 5'd15);
    cargar = 1'b0;
    tick(1);
    chk("enter_one_cycle", enter, 1'b0);
    cancelar = 1'b1; tick(2);
    cancelar = 1'b0; tick(1);
    chk("cancel_ignored_ocupado", ocupado, 1'b1);
    chk("cancel_ignored_R", R, 5'd5);
    tick(3);
    fin_ciclo = 1'b1; tick(2);
    chk("fin_not_yet", fase, 3'b000);
    tick(1);
    fin_ciclo = 1'b0;
    chk("fin_fase", fase, 3'b001);
    chk("fin_B", B, 5'd16);
    chk("fin_ocupado", ocupado, 1'b0);
    chk("fin_R_kept", R, 5'd5);
    chk("fin_G_kept", G, 5'd10);
    tick(4);

    // Timeout: confirm at c, press at c+12 ignored, error at c+20.
    load(4'd1); load(4'd2); load(4'd3);
    raise_wait(4'd0);
    tick(1);
    chk("tmo_ocupado", ocupado, 1'b1);
    cargar = 1'b0; tick(6);
    dato = 4'd9; cargar = 1'b1; tick(6);
    chk("press_ignored_fase", fase, 3'b000);
    chk("press_ignored_R", R, 5'd1);
    tick(7);
    chk("tmo_not_yet_error", error, 1'b0);
    chk("tmo_not_yet_fase", fase, 3'b000);
    tick(1);
    chk("tmo_error", error, 1'b1);
    chk("tmo_fase", fase, 3'b001);
    chk("tmo_ocupado_off", ocupado, 1'b0);
    chk("tmo_B", B, 5'd16);
    tick(10);
    chk("held_after_tmo", fase, 3'b001);
    release_btn();

    // Cancel coincident with the press edge k+5.
    load(4'd7); load(4'd3);
    chk("pre_cancel_R", R, 5'd7);
    chk("pre_cancel_G", G, 5'd3);
    chk("error_sticky", error, 1'b1);
    dato = 4'd9; cargar = 1'b1; tick(3);
    cancelar = 1'b1; tick(1);
    cancelar = 1'b0; tick(1);
    chk("cancel_pre_fase", fase, 3'b100);
    tick(1);
    chk("cancel_R", R, 5'd0);
    chk("cancel_G", G, 5'd0);
    chk("cancel_B", B, 5'd16);
    chk("cancel_fase", fase, 3'b001);
    tick(5);
    chk("cancel_no_capture", fase, 3'b001);
    release_btn();

    // Next confirm clears error; then reset asynchronously mid-pulse.
    load(4'd4); load(4'd4); load(4'd4);
    raise_wait(4'd0);
    @(posedge clk); #2;
    chk("confirm_enter", enter, 1'b1);
    chk("confirm_clears_error", error, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_R", R, 5'd0);
    chk("arst_G", G, 5'd0);
    chk("arst_B", B, 5'd16);
    chk("arst_enter", enter, 1'b0);
    chk("arst_fase", fase, 3'b001);
    chk("arst_ocupado", ocupado, 1'b0);
    chk("arst_error", error, 1'b0);
    cargar = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
